// File: rtl/clk_tick_gen.sv
// Multi-channel tick and square-wave generator: per channel, a one-cycle enable pulse every div cycles.
// Defining CLK_TICK_DIV_WR_EN makes the divisors writable at run time through div_wr/div_wr_ch/div_wr_data.
module clk_tick_gen #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
      {27'd25_000_000, 27'd200_000, 27'd50_000_000, 27'd100_000_000}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 sync_clr,
`ifdef CLK_TICK_DIV_WR_EN
   input  logic                 div_wr,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_wr_ch,
   input  logic [CNT_W-1:0]     div_wr_data,
`endif
   output logic [NUM_CH-1:0]    tick,
   output logic [NUM_CH-1:0]    sq
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_cur;
      logic [CNT_W-1:0] div_last;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;
      logic             active;
      logic             term;
      logic             wr_hit;

`ifdef CLK_TICK_DIV_WR_EN
      logic [CNT_W-1:0] div_q, div_d;

      // Indices >= NUM_CH never match any channel, so such writes are dropped.
      assign wr_hit  = div_wr && (int'(div_wr_ch) == i);
      assign div_cur = div_q;
      assign div_d   = wr_hit ? div_wr_data : div_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            div_q <= DIV_INIT[i*CNT_W +: CNT_W];
         end else begin
            div_q <= div_d;
         end
      end
`else
      assign wr_hit  = 1'b0;
      assign div_cur = DIV_INIT[i*CNT_W +: CNT_W];
`endif

      assign active   = en && ch_en[i];
      // Divisors 0 and 1 both collapse to a terminal count of 0: tick every active cycle.
      assign div_last = (div_cur <= CNT_W'(1)) ? '0 : div_cur - CNT_W'(1);
      assign term     = (cnt_q >= div_last);

      always_comb begin
         cnt_d  = cnt_q;
         sq_d   = sq_q;
         tick_d = 1'b0;
         if (sync_clr) begin
            cnt_d = '0;
            sq_d  = 1'b0;
         end else if (wr_hit) begin
            cnt_d = '0;
         end else if (active) begin
            if (term) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               sq_d   = ~sq_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
         end
      end

      assign tick[i] = tick_q;
      assign sq[i]   = sq_q;
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Scoreboard bench for clk_tick_gen: a per-channel active-edge model predicts tick/sq after every edge.
module tb_clk_tick_gen;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd1, 8'd3, 8'd5};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              sync_clr = 1'b0;
   logic [NUM_CH-1:0] ch_en = '0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;
`ifdef CLK_TICK_DIV_WR_EN
   logic              div_wr = 1'b0;
   logic [1:0]        div_wr_ch = '0;
   logic [CNT_W-1:0]  div_wr_data = '0;
`endif

   clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .ch_en       (ch_en),
      .sync_clr    (sync_clr),
`ifdef CLK_TICK_DIV_WR_EN
      .div_wr      (div_wr),
      .div_wr_ch   (div_wr_ch),
      .div_wr_data (div_wr_data),
`endif
      .tick        (tick),
      .sq          (sq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] sq;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   // Model: active edges counted since the last phase origin; sq flips once per completed period.
   int   m_n[NUM_CH];
   int   m_d[NUM_CH];
   bit   m_sqb[NUM_CH];
   logic [NUM_CH*CNT_W-1:0] init_v = DIV_INIT;

   function automatic int deff(input int d);
      return (d <= 1) ? 1 : d;
   endfunction

   function automatic bit model_sq(input int i);
      return m_sqb[i] ^ (((m_n[i] / deff(m_d[i])) % 2) == 1);
   endfunction

   task automatic apply(input bit r, input bit e, input logic [NUM_CH-1:0] ce,
                        input bit sc, input bit wr, input int wch, input int wdata);
      exp_t x;
      bit   wr_eff;
      @(negedge clk);
      rst_n    = r;
      en       = e;
      ch_en    = ce;
      sync_clr = sc;
`ifdef CLK_TICK_DIV_WR_EN
      div_wr      = wr;
      div_wr_ch   = 2'(wch);
      div_wr_data = CNT_W'(wdata);
      wr_eff      = wr;
`else
      wr_eff      = 1'b0;
`endif
      x = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!r) begin
            m_n[i]   = 0;
            m_sqb[i] = 1'b0;
            m_d[i]   = int'(init_v[i*CNT_W +: CNT_W]);
         end else if (sc) begin
            m_n[i]   = 0;
            m_sqb[i] = 1'b0;
            if (wr_eff && wch == i) m_d[i] = wdata % 256;
         end else if (wr_eff && wch == i) begin
            m_sqb[i] = model_sq(i);
            m_d[i]   = wdata % 256;
            m_n[i]   = 0;
         end else if (e && ce[i]) begin
            m_n[i]++;
            x.tick[i] = ((m_n[i] % deff(m_d[i])) == 0);
         end
         x.sq[i] = model_sq(i);
      end
      exp_q.push_back(x);
   endtask

   task automatic run(input int n, input logic [NUM_CH-1:0] ce);
      for (int k = 0; k < n; k++) apply(1'b1, 1'b1, ce, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({tick, sq} !== {e.tick, e.sq}) begin
               miscompares++;
               if (miscompares <= 20)
                  $display("FAIL tick_sq cycle %0d: got tick=%b sq=%b, expected tick=%b sq=%b",
                           cycle, tick, sq, e.tick, e.sq);
            end
         end
      end
   end

   initial begin : stim
      int guard;
      apply(1'b0, 1'b1, '1, 1'b0, 1'b0, 0, 0);
      apply(1'b0, 1'b1, '1, 1'b0, 1'b0, 0, 0);
      run(30, '1);
      guard = 0;
      while ((m_n[0] % 5) != 2 && guard < 10) begin
         run(1, '1);
         guard++;
      end
      run(7, 3'b110);
      run(12, '1);
      for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, '1, 1'b0, 1'b0, 0, 0);
      run(7, '1);
      apply(1'b1, 1'b1, '1, 1'b1, 1'b0, 0, 0);
      run(35, '1);
      apply(1'b1, 1'b1, '1, 1'b0, 1'b1, 0, 2);
      run(10, '1);
      apply(1'b1, 1'b1, '1, 1'b0, 1'b1, 3, 7);
      run(10, '1);
      apply(1'b1, 1'b1, '1, 1'b1, 1'b1, 1, 4);
      run(12, '1);
      apply(1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 2, 3);
      run(10, '1);
      apply(1'b0, 1'b1, '1, 1'b0, 1'b0, 0, 0);
      run(20, '1);
      for (int k = 0; k < 3000; k++) begin
         apply(($urandom % 200) != 0, ($urandom % 8) != 0, NUM_CH'($urandom),
               ($urandom % 50) == 0, ($urandom % 20) == 0,
               int'($urandom % 4), int'($urandom % 10));
      end
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised multi-channel tick generator, successor to the single fixed-rate 500 Hz divider in the stopwatch. From the 100 MHz board clock it produces NUM_CH independent one-cycle enable pulses (`tick`) and matching 50 %-duty square waves (`sq`). Each channel has its own divisor, enable and pause, and all channels can be phase-aligned on demand. It sits between the clock input and the stopwatch counter, display-multiplex and blink logic, which consume `tick` as clock enables on `clk`; `tick` and `sq` are never used as clocks.

## Interface
- NUM_CH, 4, number of channels (1..16)
- CNT_W, 27, counter/divisor width per channel
- DIV_INIT, {25_000_000, 200_000, 50_000_000, 100_000_000}, packed NUM_CH*CNT_W reset divisors. Channel 0 is in the LSBs, so the default gives ch0=1 Hz, ch1=2 Hz, ch2=500 Hz, ch3=4 Hz.
- clk  in  1  system clock, 100 MHz, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  global run enable
- ch_en  in  NUM_CH  per-channel run enable
- sync_clr  in  1  restart all channel counters in phase
- div_wr  in  1  divisor write strobe (only with CLK_TICK_DIV_WR_EN)
- div_wr_ch  in  CH_W  target channel, where CH_W = max(1, clog2(NUM_CH)) (only with macro)
- div_wr_data  in  CNT_W  new divisor (only with macro)
- tick  out  NUM_CH  one-cycle pulse per channel period, registered
- sq  out  NUM_CH  square wave, toggles on each tick, registered

## Operation
- Per-channel state:
  - `cnt[i]`, CNT_W bits
  - `div[i]`, CNT_W bits, initialised from DIV_INIT
  - `sq[i]`
- A channel is active when `en & ch_en[i]`.
- Active channel, normal count:
  - If `cnt[i] == div[i]-1`: `cnt[i]` becomes 0, `tick[i]` becomes 1, `sq[i]` toggles.
  - Otherwise: `cnt[i]` increments and `tick[i]` becomes 0.
- Tick period is exactly `div[i]` cycles. `sq` period is `2*div[i]` cycles.
- Divisor of 0 or 1 is treated as 1: `tick[i]` stays high on every active cycle and `sq[i]` toggles every cycle.
- Inactive channel (paused): `cnt[i]` and `sq[i]` hold, `tick[i]` is 0. On resume, counting continues from the held count with no phase loss.
- Control priority, highest first:
  1. `rst_n` low: all `cnt` = 0, all `tick` = 0, all `sq` = 0, `div` reloaded from DIV_INIT.
  2. `sync_clr`: all `cnt` = 0, all `tick` = 0, all `sq` = 0. Applies whether or not the channel is enabled. `div` is kept.
  3. Divisor write: see Configuration.
  4. Normal count.
- Each DIV_INIT field must fit in CNT_W. A value of 0 behaves as 1.

## Timing
- Reset values: `tick` = 0, `sq` = 0 on every channel.
- After the first edge with `rst_n` = 1 and the channel active, `tick[i]` is first high in the cycle following the `div[i]`-th active edge. It is then high for exactly one cycle and repeats every `div[i]` active cycles.
- `sync_clr` asserted at edge k: outputs are 0 after edge k. The next tick follows edge k + `div[i]`, given continuous activity.
- Output latency is zero extra: `tick` and `sq` are flops updated on the same edge as `cnt`.
- Reset asserted mid-period: all state is discarded at that edge, with no partial tick.
- Pause on the terminal-count cycle: the tick is deferred to the first active edge after resume.

## Configuration
- `CLK_TICK_DIV_WR_EN` defined:
  - `div_wr`, `div_wr_ch` and `div_wr_data` exist.
  - When `div_wr` = 1 at an edge: `div[div_wr_ch]` takes `div_wr_data`, `cnt` of that channel becomes 0 and its `tick` becomes 0. `sq` is held.
  - Writes to a channel index >= NUM_CH are ignored.
  - `sync_clr` together with `div_wr` in the same cycle: both take effect (new divisor, all counters cleared).
  - A write while the channel is paused still updates it.
- `CLK_TICK_DIV_WR_EN` undefined:
  - The three ports are absent.
  - `div[i]` are constants from DIV_INIT and need no registers.

## Test plan
- Reset and period. NUM_CH=3, CNT_W=8, DIV_INIT {1,3,5}, all enables 1. Release reset → ch0 ticks every 5 cycles, first tick after edge 5. ch1 ticks every 3 cycles. ch2 `tick` is constantly 1. `sq0` has a period of 10.
- Pause. Drop `ch_en[0]` for 7 cycles at `cnt0` = 2 → no `tick0` and `sq0` held during the pause. The next `tick0` comes 3 active cycles after resume. ch1 is unaffected.
- Global enable. Set `en` = 0 → all `tick` are 0 and all `sq` are frozen, including ch2 (divisor 1).
- Phase align. Assert `sync_clr` mid-period → all `tick`/`sq` are 0 the next cycle. ch0 and ch1 then tick together at edge 15 after the clear, and every 15 cycles after that.
- Divisor write (with macro). Write 2 to ch0 while `sync_clr` = 0 → `tick0` is low for one cycle, then the period is 2. A write to channel 3 leaves all channels unchanged.
- Reset mid-operation. Assert `rst_n` = 0 for 1 cycle at an arbitrary point after a divisor write → `div0` reverts to 5 and the first-tick timing of the reset test is repeated.
